// File: rtl/cpc_video_out.sv
// cpc_video_out: Gate Array colour/sync conditioner: tri-level RGB decode, fixed-width HSYNC, line-aligned VSYNC, active window, line lock. Optional macro CPC_VIDEO_MONO_EN adds green-screen luma.
// Latency: 2 ce_16 ticks from inputs to r/g/b/de/sync outputs (both builds).
// Backpressure: none; free-running on ce_16, every register except ce_pix holds while ce_16 is low.
module cpc_video_out #(
   parameter logic [9:0] H_START    = 10'd160,
   parameter logic [9:0] H_WIDTH    = 10'd768,
   parameter logic [8:0] V_START    = 9'd24,
   parameter logic [8:0] V_HEIGHT   = 9'd270,
   parameter logic [6:0] HS_LEN     = 7'd64,
   parameter logic [2:0] LOCK_LINES = 3'd4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ce_16,
   input  logic [1:0] red_in,
   input  logic [1:0] green_in,
   input  logic [1:0] blue_in,
   input  logic       hblank_in,
   input  logic       vblank_in,
   input  logic       hsync_in,
   input  logic       vsync_in,
`ifdef CPC_VIDEO_MONO_EN
   input  logic       mono_en,
`endif
   output logic [7:0] r_out,
   output logic [7:0] g_out,
   output logic [7:0] b_out,
   output logic       de_out,
   output logic       hsync_out,
   output logic       vsync_out,
   output logic       ce_pix,
   output logic       locked
);

   function automatic logic [7:0] dec_col(input logic [1:0] c);
      if (c[0])
         return 8'h80;
      return c[1] ? 8'hFF : 8'h00;
   endfunction

   // stage 1
   logic [1:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;
   logic        hblank_q, hblank_d, vblank_q, vblank_d;
   logic        hsync_q, hsync_d, vsync_q, vsync_d;
   logic        hsync_p_q, hsync_p_d, vsync_p_q, vsync_p_d;
   logic        s1_vld_q, s1_vld_d, p_vld_q, p_vld_d;
   // stage 2
   logic [10:0] hcnt_q, hcnt_d;
   logic [8:0]  vcnt_q, vcnt_d;
   logic        vs_lat_q, vs_lat_d;
   logic [6:0]  hs_cnt_q, hs_cnt_d;
   logic [11:0] prev_period_q, prev_period_d;
   logic [2:0]  match_q, match_d;
   logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
   logic        de_q, de_d, hs_o_q, hs_o_d, vs_o_q, vs_o_d;
   logic        ce_pix_q, ce_pix_d, locked_q, locked_d;

   logic        hs_rise, vs_rise, win;
   logic [11:0] period;
   logic [7:0]  r_dec, g_dec, b_dec;
   logic [10:0] h_end, v_end;

   // An edge needs two real stage-1 samples, so a sync held high through reset is not an edge.
   assign hs_rise = hsync_q & ~hsync_p_q & p_vld_q;
   assign vs_rise = vsync_q & ~vsync_p_q & p_vld_q;
   assign r_dec   = dec_col(red_q);
   assign g_dec   = dec_col(green_q);
   assign b_dec   = dec_col(blue_q);
   assign h_end   = {1'b0, H_START} + {1'b0, H_WIDTH};
   assign v_end   = {2'b00, V_START} + {2'b00, V_HEIGHT};

`ifdef CPC_VIDEO_MONO_EN
   logic [15:0] luma;
   assign luma = 16'd77 * {8'h00, r_dec} + 16'd151 * {8'h00, g_dec} + 16'd28 * {8'h00, b_dec};
`endif

   always_comb begin
      red_d         = red_q;
      green_d       = green_q;
      blue_d        = blue_q;
      hblank_d      = hblank_q;
      vblank_d      = vblank_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      hsync_p_d     = hsync_p_q;
      vsync_p_d     = vsync_p_q;
      s1_vld_d      = s1_vld_q;
      p_vld_d       = p_vld_q;
      hcnt_d        = hcnt_q;
      vcnt_d        = vcnt_q;
      vs_lat_d      = vs_lat_q;
      hs_cnt_d      = hs_cnt_q;
      prev_period_d = prev_period_q;
      match_d       = match_q;
      r_d           = r_q;
      g_d           = g_q;
      b_d           = b_q;
      de_d          = de_q;
      hs_o_d        = hs_o_q;
      vs_o_d        = vs_o_q;
      locked_d      = locked_q;
      ce_pix_d      = ce_16;
      period        = {1'b0, hcnt_q} + 12'd1;
      win           = 1'b0;

      if (ce_16) begin
         red_d     = red_in;
         green_d   = green_in;
         blue_d    = blue_in;
         hblank_d  = hblank_in;
         vblank_d  = vblank_in;
         hsync_d   = hsync_in;
         vsync_d   = vsync_in;
         hsync_p_d = hsync_q;
         vsync_p_d = vsync_q;
         s1_vld_d  = 1'b1;
         p_vld_d   = s1_vld_q;

         if (hs_rise)
            hcnt_d = 11'd0;
         else if (hcnt_q != 11'h7FF)
            hcnt_d = hcnt_q + 11'd1;

         if (hs_rise) begin
            if (vs_lat_q || vs_rise)
               vcnt_d = 9'd0;
            else if (vcnt_q != 9'h1FF)
               vcnt_d = vcnt_q + 9'd1;
            vs_lat_d = 1'b0;
            vs_o_d   = vsync_q;
         end else if (vs_rise) begin
            vs_lat_d = 1'b1;
         end

         if (hs_rise)
            hs_cnt_d = HS_LEN;
         else if (hs_cnt_q != 7'd0)
            hs_cnt_d = hs_cnt_q - 7'd1;
         hs_o_d = (hs_cnt_d != 7'd0);

         // period spans the previous line, ending on the tick before this hs_rise
         if (hs_rise) begin
            if (period == prev_period_q)
               match_d = (match_q == LOCK_LINES) ? match_q : match_q + 3'd1;
            else
               match_d = 3'd0;
            prev_period_d = period;
         end
         locked_d = (match_d == LOCK_LINES);

         win = (hcnt_d >= {1'b0, H_START}) && (hcnt_d < h_end) &&
               ({2'b00, vcnt_d} >= {2'b00, V_START}) && ({2'b00, vcnt_d} < v_end);
         de_d = win && !hblank_q && !vblank_q;
         r_d  = de_d ? r_dec : 8'h00;
         g_d  = de_d ? g_dec : 8'h00;
         b_d  = de_d ? b_dec : 8'h00;
`ifdef CPC_VIDEO_MONO_EN
         if (mono_en) begin
            r_d = 8'h00;
            g_d = de_d ? luma[15:8] : 8'h00;
            b_d = 8'h00;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         red_q         <= 2'b00;
         green_q       <= 2'b00;
         blue_q        <= 2'b00;
         hblank_q      <= 1'b0;
         vblank_q      <= 1'b0;
         hsync_q       <= 1'b0;
         vsync_q       <= 1'b0;
         hsync_p_q     <= 1'b0;
         vsync_p_q     <= 1'b0;
         s1_vld_q      <= 1'b0;
         p_vld_q       <= 1'b0;
         hcnt_q        <= 11'h7FF;
         vcnt_q        <= 9'h1FF;
         vs_lat_q      <= 1'b0;
         hs_cnt_q      <= 7'd0;
         prev_period_q <= 12'd0;
         match_q       <= 3'd0;
         r_q           <= 8'h00;
         g_q           <= 8'h00;
         b_q           <= 8'h00;
         de_q          <= 1'b0;
         hs_o_q        <= 1'b0;
         vs_o_q        <= 1'b0;
         ce_pix_q      <= 1'b0;
         locked_q      <= 1'b0;
      end else begin
         red_q         <= red_d;
         green_q       <= green_d;
         blue_q        <= blue_d;
         hblank_q      <= hblank_d;
         vblank_q      <= vblank_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         hsync_p_q     <= hsync_p_d;
         vsync_p_q     <= vsync_p_d;
         s1_vld_q      <= s1_vld_d;
         p_vld_q       <= p_vld_d;
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         vs_lat_q      <= vs_lat_d;
         hs_cnt_q      <= hs_cnt_d;
         prev_period_q <= prev_period_d;
         match_q       <= match_d;
         r_q           <= r_d;
         g_q           <= g_d;
         b_q           <= b_d;
         de_q          <= de_d;
         hs_o_q        <= hs_o_d;
         vs_o_q        <= vs_o_d;
         ce_pix_q      <= ce_pix_d;
         locked_q      <= locked_d;
      end
   end

   assign r_out     = r_q;
   assign g_out     = g_q;
   assign b_out     = b_q;
   assign de_out    = de_q;
   assign hsync_out = hs_o_q;
   assign vsync_out = vs_o_q;
   assign ce_pix    = ce_pix_q;
   assign locked    = locked_q;

endmodule

// File: tb/tb_cpc_video_out.sv
// Directed bench for cpc_video_out: lines are driven pixel by pixel and each output sample is filed
// under the pixel index it belongs to (two ticks back), then checked against hand-computed values.
module tb_cpc_video_out;

   logic       clk = 1'b0;
   logic       reset, ce_16;
   logic [1:0] red_in, green_in, blue_in;
   logic       hblank_in, vblank_in, hsync_in, vsync_in;
   logic [7:0] r_out, g_out, b_out;
   logic       de_out, hsync_out, vsync_out, ce_pix, locked;
`ifdef CPC_VIDEO_MONO_EN
   logic       mono_en = 1'b0;
`endif

   cpc_video_out dut (
      .clk       (clk),
      .reset     (reset),
      .ce_16     (ce_16),
      .red_in    (red_in),
      .green_in  (green_in),
      .blue_in   (blue_in),
      .hblank_in (hblank_in),
      .vblank_in (vblank_in),
      .hsync_in  (hsync_in),
      .vsync_in  (vsync_in),
`ifdef CPC_VIDEO_MONO_EN
      .mono_en   (mono_en),
`endif
      .r_out     (r_out),
      .g_out     (g_out),
      .b_out     (b_out),
      .de_out    (de_out),
      .hsync_out (hsync_out),
      .vsync_out (vsync_out),
      .ce_pix    (ce_pix),
      .locked    (locked)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   logic       de_h [0:2047];
   logic       hs_h [0:2047];
   logic       vs_h [0:2047];
   logic       lk_h [0:2047];
   logic [7:0] r_h  [0:2047];
   logic [7:0] g_h  [0:2047];
   logic [7:0] b_h  [0:2047];

   int last_pix = -1;
   int hb_lo = 0, hb_hi = 0, vb_lo = 0, vb_hi = 0;
   int col_sw = 4096;
   int hold_at = -1;
   bit all_full = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int pix);
      ce_16 = 1'b1;
      @(posedge clk);
      #1;
      ce_16 = 1'b0;
      if (last_pix >= 0) begin
         de_h[last_pix] = de_out;
         hs_h[last_pix] = hsync_out;
         vs_h[last_pix] = vsync_out;
         lk_h[last_pix] = locked;
         r_h[last_pix]  = r_out;
         g_h[last_pix]  = g_out;
         b_h[last_pix]  = b_out;
      end
      last_pix = pix;
      if (pix == hold_at) begin
         check_eq("ce_pix_on", 32'(ce_pix), 32'd1);
         repeat (3) @(posedge clk);
         #1;
         check_eq("hold_r", 32'(r_out), 32'h80);
         check_eq("hold_de", 32'(de_out), 32'd1);
         check_eq("ce_pix_off", 32'(ce_pix), 32'd0);
      end
   endtask

   task automatic run_seg(input int p0, input int p1, input int hs_w, input int vs_from);
      for (int p = p0; p < p1; p++) begin
         hsync_in  = (p < hs_w);
         vsync_in  = (p >= vs_from);
         hblank_in = (p >= hb_lo) && (p < hb_hi);
         vblank_in = (p >= vb_lo) && (p < vb_hi);
         if (all_full) begin
            red_in = 2'b10; green_in = 2'b10; blue_in = 2'b10;
         end else if (p >= col_sw) begin
            red_in = 2'b10; green_in = 2'b00; blue_in = 2'b01;
         end else begin
            red_in = 2'b01; green_in = 2'b10; blue_in = 2'b00;
         end
         tick(p);
      end
   endtask

   int lens  [12] = '{1024, 1024, 1024, 1024, 1024, 1020, 1024, 1024, 1024, 1024, 1024, 1024};
   int hsw   [12] = '{80, 10, 80, 80, 80, 80, 80, 80, 80, 80, 80, 80};
   int exp_lk[12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};

   initial begin
      int cnt;
      int zbad;
      reset = 1'b1; ce_16 = 1'b1;
      red_in = 2'b00; green_in = 2'b00; blue_in = 2'b00;
      hblank_in = 1'b0; vblank_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      ce_16 = 1'b0;
      check_eq("rst_rgb", {8'h00, r_out, g_out, b_out}, 32'h0);
      check_eq("rst_flags", 32'({de_out, hsync_out, vsync_out, ce_pix, locked}), 32'h0);
      reset = 1'b0;

      run_seg(0, 20, 0, 4096);

      // lock acquisition, loss on a short line, reacquisition; hsync width per line
      for (int i = 0; i < 12; i++) begin
         run_seg(0, lens[i], hsw[i], 4096);
         check_eq($sformatf("lock_l%0d", i + 1), 32'(lk_h[0]), 32'(exp_lk[i]));
         cnt = 0;
         for (int k = 0; k < lens[i] - 1; k++) cnt += int'(hs_h[k]);
         check_eq($sformatf("hs_w_l%0d", i + 1), 32'(cnt), 32'd64);
      end

      // vsync rises mid-line; output follows only at the next hsync rise
      run_seg(0, 1024, 80, 500);
      check_eq("vs_mid_600", 32'(vs_h[600]), 32'd0);
      check_eq("vs_mid_1000", 32'(vs_h[1000]), 32'd0);

      for (int ln = 0; ln < 295; ln++) begin
         col_sw  = (ln == 24) ? 600 : 4096;
         hold_at = (ln == 24) ? 300 : -1;
         hb_lo   = (ln == 24) ? 700 : 0;
         hb_hi   = (ln == 24) ? 710 : 0;
         vb_lo   = (ln == 25) ? 160 : 0;
         vb_hi   = (ln == 25) ? 170 : 0;
`ifdef CPC_VIDEO_MONO_EN
         mono_en  = (ln == 30);
         all_full = (ln == 30);
`endif
         run_seg(0, (ln == 24) ? 1024 : 170, 80, (ln < 3) ? 0 : 4096);
         case (ln)
            0:   check_eq("vs_line0", 32'(vs_h[0]), 32'd1);
            3:   check_eq("vs_line3", 32'(vs_h[0]), 32'd0);
            23:  check_eq("de_l23", 32'(de_h[165]), 32'd0);
            24: begin
               check_eq("de_h159", 32'(de_h[159]), 32'd0);
               check_eq("de_h160", 32'(de_h[160]), 32'd1);
               check_eq("de_h927", 32'(de_h[927]), 32'd1);
               check_eq("de_h928", 32'(de_h[928]), 32'd0);
               check_eq("r_500", 32'(r_h[500]), 32'h80);
               check_eq("g_500", 32'(g_h[500]), 32'hFF);
               check_eq("b_500", 32'(b_h[500]), 32'h00);
               check_eq("r_599", 32'(r_h[599]), 32'h80);
               check_eq("r_600", 32'(r_h[600]), 32'hFF);
               check_eq("g_600", 32'(g_h[600]), 32'h00);
               check_eq("b_600", 32'(b_h[600]), 32'h80);
               check_eq("de_hblank", 32'(de_h[705]), 32'd0);
               cnt = 0;
               zbad = 0;
               for (int k = 0; k < 1023; k++) begin
                  cnt += int'(de_h[k]);
                  if (!de_h[k] && (r_h[k] | g_h[k] | b_h[k]) != 8'h00) zbad++;
               end
               check_eq("de_count_l24", 32'(cnt), 32'd758);
               check_eq("rgb_zero_no_de", 32'(zbad), 32'd0);
            end
            25:  check_eq("de_vblank", 32'(de_h[165]), 32'd0);
            26:  check_eq("de_l26", 32'(de_h[165]), 32'd1);
`ifdef CPC_VIDEO_MONO_EN
            30: begin
               check_eq("mono_g", 32'(g_h[165]), 32'((77 * 255 + 151 * 255 + 28 * 255) >> 8));
               check_eq("mono_rb", 32'({r_h[165], b_h[165]}), 32'h0);
            end
`endif
            293: check_eq("de_l293", 32'(de_h[165]), 32'd1);
            294: check_eq("de_l294", 32'(de_h[165]), 32'd0);
            default: ;
         endcase
      end
      col_sw = 4096; hold_at = -1; hb_hi = 0; vb_hi = 0;

      // reset 10 ticks into an hsync_out pulse
      run_seg(0, 11, 80, 4096);
      check_eq("hs_pre_rst", 32'(hsync_out), 32'd1);
      check_eq("lk_pre_rst", 32'(locked), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_eq("mid_rst_rgb", {8'h00, r_out, g_out, b_out}, 32'h0);
      check_eq("mid_rst_flags", 32'({de_out, hsync_out, vsync_out, ce_pix, locked}), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      last_pix = -1;
      run_seg(11, 1024, 80, 4096);
      cnt = 0;
      for (int k = 11; k < 1023; k++) cnt += int'(hs_h[k]);
      check_eq("hs_after_rst", 32'(cnt), 32'd0);
      run_seg(0, 1024, 80, 4096);
      cnt = 0;
      for (int k = 0; k < 1023; k++) cnt += int'(hs_h[k]);
      check_eq("hs_fresh", 32'(cnt), 32'd64);
      check_eq("hs_fresh_0", 32'(hs_h[0]), 32'd1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
